// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: register addresses used by both the top-level
// address decode and the sprite DMA sequencer, plus the DMA state encoding.
package nes_bus_pkg;

    // Sprite DMA trigger register (CPU write starts a transfer)
    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    // PPU OAM data port, the destination of every DMA byte
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        DUMMY,
        ALIGN,
        READ,
        WAIT,
        WRITE
    } dma_state_t;

    // Source address of byte idx within a 256-byte page; idx never carries
    // into the page byte.
    function automatic logic [15:0] page_addr(input logic [7:0] page,
                                              input logic [7:0] idx);
        return {page, idx};
    endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite DMA sequencer. Snoops CPU writes for the trigger register, then owns
// the bus: one dummy cycle, an optional alignment cycle on odd parity, and
// 256 read/write pairs copying {page,00}..{page,FF} into the OAM data port.
module oam_dma_controller
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR  = ADDR_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
    parameter int          READ_LATENCY  = 1
) (
    input  logic        cpu_clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr_en,
    input  logic [7:0]  cpu_dout,
    input  logic [7:0]  dma_din,
    output logic        dma_en,
    output logic [15:0] dma_addr,
    output logic        dma_wr_en,
    output logic [7:0]  dma_dout,
    output logic        dma_done
);

    // WAIT lasts READ_LATENCY-1 cycles; the counter runs 0..WAIT_LAST.
    localparam int WAIT_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
    localparam int WAIT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

    dma_state_t        state;
    dma_state_t        state_next;
    logic [7:0]        page;
    logic [7:0]        idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              parity;

    logic trigger_hit;
    logic last_byte;
    logic wait_over;

    assign trigger_hit = cpu_wr_en && (cpu_addr == TRIGGER_ADDR);
    assign last_byte   = (idx == 8'hFF);
    assign wait_over   = (wait_cnt == WAIT_W'(WAIT_LAST));

    // Next-state selection for the transfer sequence
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        state_next = state;
        unique case (state)
            IDLE:    if (trigger_hit) state_next = DUMMY;
            DUMMY:   state_next = parity ? ALIGN : READ;
            ALIGN:   state_next = READ;
            READ:    state_next = (READ_LATENCY > 1) ? WAIT : WRITE;
            WAIT:    if (wait_over) state_next = WRITE;
            WRITE:   state_next = last_byte ? IDLE : READ;
            default: state_next = IDLE;
        endcase
    end

    // State, page/index, wait counter, parity and done-pulse registers
    always_ff @(posedge cpu_clock) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state    <= IDLE;
            page     <= 8'h00;
            idx      <= 8'h00;
            wait_cnt <= '0;
            parity   <= 1'b0;
            dma_done <= 1'b0;
        end else begin
            state    <= state_next;
            // Parity free-runs from reset; transfers never touch it.
            parity   <= ~parity;
            dma_done <= (state == WRITE) && last_byte;

            if (state == IDLE && trigger_hit) begin
                page <= cpu_dout;
                idx  <= 8'h00;
            end else if (state == WRITE && !last_byte) begin
                idx <= idx + 8'h01;
            end

            if (state == READ) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Bus outputs decoded from registered state only; write data is the
    // read data passed straight through in the WRITE cycle.
    always_comb begin
        dma_en    = 1'b0;
        dma_addr  = 16'h0000;
        dma_wr_en = 1'b0;
        dma_dout  = 8'h00;
        unique case (state)
            DUMMY, ALIGN: begin
                dma_en   = 1'b1;
                dma_addr = page_addr(page, 8'h00);
            end
            READ, WAIT: begin
                dma_en   = 1'b1;
                dma_addr = page_addr(page, idx);
            end
            WRITE: begin
                dma_en    = 1'b1;
                dma_addr  = OAM_DATA_ADDR;
                dma_wr_en = 1'b1;
                dma_dout  = dma_din;
            end
            default: begin
                dma_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for the sprite DMA sequencer. Two instances run side by
// side on the same CPU stimulus: instance 0 with READ_LATENCY=1 and
// instance 1 with READ_LATENCY=2, each behind its own bus read model.
module tb_oam_dma_controller;

    logic        cpu_clock;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_wr_en;
    logic [7:0]  cpu_dout;

    logic [7:0]  dma_din   [2];
    logic        dma_en    [2];
    logic [15:0] dma_addr  [2];
    logic        dma_wr_en [2];
    logic [7:0]  dma_dout  [2];
    logic        dma_done  [2];

    // Per-instance transfer statistics, written only by the monitors
    int          en_cnt    [2];
    int          wr_cnt    [2];
    int          first_wr  [2];
    int          done_cnt  [2];
    int          bad_addr  [2];
    int          bad_data  [2];
    int          bad_done  [2];
    logic [15:0] last_rd   [2];
    logic        prev_wr   [2];
    int          seen_tok  [2];

    // Written only by the main stimulus process
    int          clr_tok   [2];
    logic [7:0]  exp_page  [2];
    logic        exp_par   [2];

    logic        tb_par;
    int          n_tests;
    int          n_fail;

    initial cpu_clock = 1'b0;
    always #5 cpu_clock = ~cpu_clock;

    // Reference parity: 0 in the first cycle after reset, toggling each cycle
    always @(posedge cpu_clock) tb_par <= reset ? 1'b0 : ~tb_par;

    // Bus contents seen by the DMA: page 2 holds i^A5 at $02xx
    function automatic logic [7:0] bus_byte(input logic [15:0] a);
        return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] s1;
        logic [7:0] s2;

        oam_dma_controller #(
            .READ_LATENCY(g + 1)
        ) u_dut (
            .cpu_clock (cpu_clock),
            .reset     (reset),
            .cpu_addr  (cpu_addr),
            .cpu_wr_en (cpu_wr_en),
            .cpu_dout  (cpu_dout),
            .dma_din   (dma_din[g]),
            .dma_en    (dma_en[g]),
            .dma_addr  (dma_addr[g]),
            .dma_wr_en (dma_wr_en[g]),
            .dma_dout  (dma_dout[g]),
            .dma_done  (dma_done[g])
        );

        // Read model: data for the presented address appears g+1 cycles later
        always @(posedge cpu_clock) begin
            s1 <= bus_byte(dma_addr[g]);
            s2 <= s1;
        end
        assign dma_din[g] = (g == 0) ? s1 : s2;

        // Bus monitor: checks every DMA cycle against the expected sequence
        always @(negedge cpu_clock) begin
            int          e, w, fw, dc, ba, bd, bdn;
            logic [15:0] lr;
            logic        pw;
            if (clr_tok[g] != seen_tok[g]) begin
                e = 0; w = 0; fw = -1; dc = 0; ba = 0; bd = 0; bdn = 0;
                lr = 16'h0000; pw = 1'b0;
            end else begin
                e = en_cnt[g]; w = wr_cnt[g]; fw = first_wr[g]; dc = done_cnt[g];
                ba = bad_addr[g]; bd = bad_data[g]; bdn = bad_done[g];
                lr = last_rd[g]; pw = prev_wr[g];
            end
            if (!reset) begin
                if (dma_done[g]) begin
                    dc++;
                    if (!(pw && w == 256)) bdn++;
                end
                if (dma_en[g]) begin
                    if (dma_wr_en[g]) begin
                        if (fw < 0) fw = e;
                        if (dma_addr[g] != 16'h2004) ba++;
                        if (dma_dout[g] != bus_byte({exp_page[g], w[7:0]})) bd++;
                        w++;
                    end else begin
                        if (dma_addr[g] != {exp_page[g], w[7:0]}) ba++;
                        lr = dma_addr[g];
                    end
                    e++;
                end else if (dma_wr_en[g]) begin
                    ba++;
                end
                pw = dma_en[g] && dma_wr_en[g];
            end
            en_cnt[g]   <= e;
            wr_cnt[g]   <= w;
            first_wr[g] <= fw;
            done_cnt[g] <= dc;
            bad_addr[g] <= ba;
            bad_data[g] <= bd;
            bad_done[g] <= bdn;
            last_rd[g]  <= lr;
            prev_wr[g]  <= pw;
            seen_tok[g] <= clr_tok[g];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Trigger so that parity in the DUMMY cycle equals par; with hold>0 the
    // trigger write is kept asserted (with a different page) while busy.
    task automatic start(input logic [7:0] pg, input logic par, input int hold);
        @(negedge cpu_clock);
        while (tb_par == par) @(negedge cpu_clock);
        for (int g = 0; g < 2; g++) begin
            clr_tok[g]++;
            exp_page[g] = pg;
            exp_par[g]  = par;
        end
        cpu_wr_en = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_dout  = pg;
        @(negedge cpu_clock);
        if (hold > 0) begin
            cpu_dout = 8'h55;
            repeat (hold) @(negedge cpu_clock);
        end
        cpu_wr_en = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_dout  = 8'h00;
    endtask

    // Returns #1 after the negedge of the cycle in which dma_done is high
    task automatic wait_done(input int g, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt[g] > 0) break;
            @(negedge cpu_clock);
            #1;
        end
    endtask

    task automatic check_run(input int g);
        int rl;
        rl = g + 1;
        check($sformatf("i%0d_p%0h_writes", g, exp_page[g]), wr_cnt[g], 256);
        check($sformatf("i%0d_p%0h_en_cycles", g, exp_page[g]), en_cnt[g],
              1 + int'(exp_par[g]) + 256 * (rl + 1));
        check($sformatf("i%0d_p%0h_first_write", g, exp_page[g]), first_wr[g],
              1 + int'(exp_par[g]) + rl);
        check($sformatf("i%0d_p%0h_addr_errs", g, exp_page[g]), bad_addr[g], 0);
        check($sformatf("i%0d_p%0h_data_errs", g, exp_page[g]), bad_data[g], 0);
        check($sformatf("i%0d_p%0h_done_cnt", g, exp_page[g]), done_cnt[g], 1);
        check($sformatf("i%0d_p%0h_done_timing", g, exp_page[g]), bad_done[g], 0);
        check($sformatf("i%0d_p%0h_last_read", g, exp_page[g]), last_rd[g],
              {exp_page[g], 8'hFF});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hit;
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        cpu_wr_en = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_dout  = 8'h00;
        for (int g = 0; g < 2; g++) begin
            clr_tok[g]  = 0;
            exp_page[g] = 8'h00;
            exp_par[g]  = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge cpu_clock);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("i%0d_rst_en", g), dma_en[g], 0);
            check($sformatf("i%0d_rst_wr", g), dma_wr_en[g], 0);
            check($sformatf("i%0d_rst_addr", g), dma_addr[g], 16'h0000);
            check($sformatf("i%0d_rst_dout", g), dma_dout[g], 8'h00);
            check($sformatf("i%0d_rst_done", g), dma_done[g], 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge cpu_clock);

        // Page 2, even then odd parity; page 7 with the trigger held while busy
        start(8'h02, 1'b0, 0);
        wait_done(0, 3000); check_run(0);
        wait_done(1, 3000); check_run(1);
        start(8'h02, 1'b1, 0);
        wait_done(0, 3000); check_run(0);
        wait_done(1, 3000); check_run(1);
        start(8'h07, 1'b0, 100);
        wait_done(0, 3000); check_run(0);
        wait_done(1, 3000); check_run(1);

        // CPU read of the trigger address and write to a neighbour: no transfer
        @(negedge cpu_clock);
        for (int g = 0; g < 2; g++) clr_tok[g]++;
        cpu_addr = 16'h4014; cpu_dout = 8'h09; cpu_wr_en = 1'b0;
        repeat (5) @(negedge cpu_clock);
        cpu_addr = 16'h4015; cpu_wr_en = 1'b1;
        repeat (5) @(negedge cpu_clock);
        cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_wr_en = 1'b0;
        repeat (5) @(negedge cpu_clock);
        #1;
        check("i0_no_trigger_en", en_cnt[0], 0);
        check("i1_no_trigger_en", en_cnt[1], 0);

        // Reset in the WRITE cycle of byte 100 aborts without dma_done
        start(8'h05, 1'b0, 0);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge cpu_clock);
            #1;
            if (dma_wr_en[0] && wr_cnt[0] == 101) begin
                hit = 1'b1;
                break;
            end
        end
        check("rst_byte100_reached", hit, 1);
        reset = 1'b1;
        @(negedge cpu_clock);
        check("i0_abort_en", dma_en[0], 0);
        check("i1_abort_en", dma_en[1], 0);
        check("i0_abort_wr", dma_wr_en[0], 0);
        repeat (2) @(negedge cpu_clock);
        reset = 1'b0;
        repeat (900) @(negedge cpu_clock);
        #1;
        check("i0_abort_no_done", done_cnt[0], 0);
        check("i1_abort_no_done", done_cnt[1], 0);
        check("i0_abort_writes", wr_cnt[0], 101);

        // Full run from page 3; instance 0 is retriggered (page 4) in its
        // dma_done cycle while instance 1 is still busy and must ignore it.
        start(8'h03, 1'b0, 0);
        wait_done(0, 3000);
        check_run(0);
        clr_tok[0]++;
        exp_page[0] = 8'h04;
        exp_par[0]  = ~tb_par;
        cpu_wr_en = 1'b1; cpu_addr = 16'h4014; cpu_dout = 8'h04;
        @(negedge cpu_clock);
        cpu_wr_en = 1'b0; cpu_addr = 16'h0000; cpu_dout = 8'h00;
        wait_done(1, 3000); check_run(1);
        wait_done(0, 3000); check_run(0);

        repeat (5) @(negedge cpu_clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Sprite DMA sequencer for the CPU bus.
- A CPU write to TRIGGER_ADDR latches a source page. The block then stalls the CPU and takes the bus, copying 256 bytes from {page,00}..{page,FF} to OAM_DATA_ADDR through the normal bus decode (RAM/ROM/PPU).
- Drives the top-level dma_en / bus-address override.
- Owns all sequencing that today's static dma_en/dma_addr_hi/dma_addr_lo registers lack.

Parameters:
- TRIGGER_ADDR, 16'h4014, CPU write address that starts a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address written once per byte.
- READ_LATENCY, 1, cycles from address presented to dma_din valid (>=1).

Ports:
- cpu_clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock cpu_clock.
- cpu_addr  in  16  CPU address (snooped).
- cpu_wr_en  in  1  CPU write strobe (snooped).
- cpu_dout  in  8  CPU write data (snooped; page number).
- dma_din  in  8  bus read data returned for dma_addr.
- dma_en  out  1  DMA owns bus; top level gates CPU ready and muxes address.
- dma_addr  out  16  bus address while dma_en.
- dma_wr_en  out  1  bus write strobe.
- dma_dout  out  8  bus write data.
- dma_done  out  1  one-cycle pulse after final write.

Behaviour:
- Reset values: state IDLE, dma_en=0, dma_wr_en=0, dma_addr=0, dma_dout=0, dma_done=0, page=0, byte index=0, parity=0. Reset mid-transfer aborts immediately: no further writes and no dma_done.
- Parity flop: toggles every cycle from reset and is never cleared by a transfer.
- States: IDLE, DUMMY, ALIGN, READ, WAIT, WRITE.
- IDLE:
  - On cpu_wr_en=1 and cpu_addr==TRIGGER_ADDR, latch page=cpu_dout and idx=0, then go to DUMMY.
  - Otherwise stay in IDLE.
- DUMMY: dma_en=1, dma_addr={page,8'h00}, no write. Next state is ALIGN if parity==1, else READ.
- ALIGN: same outputs as DUMMY; next state is READ.
- READ: dma_addr={page,idx}, dma_wr_en=0. Next state is WAIT if READ_LATENCY>1, else WRITE.
- WAIT: holds the READ address and counts READ_LATENCY-1 cycles, then goes to WRITE.
- WRITE:
  - dma_addr=OAM_DATA_ADDR, dma_wr_en=1, dma_dout=dma_din (pass-through; the data is valid in this cycle by the latency definition).
  - If idx==8'hFF, go to IDLE and assert dma_done in the next cycle. Otherwise idx+=1 (8-bit) and go to READ.
- idx is 8 bits, so the address never leaves the page; $xxFF does not carry into the page byte.
- Timing (READ_LATENCY=1):
  - Trigger write sampled at the edge ending cycle T; dma_en rises in T+1.
  - Total dma_en cycles: 513 with parity even in DUMMY, 514 with parity odd.
  - Per-byte cost is READ_LATENCY+1 cycles.
- dma_en=1 in every non-IDLE state. All outputs are decoded from registered state, with no combinational path from cpu_* inputs to outputs.
- Triggers arriving while not IDLE are ignored (the CPU is stalled, so none should occur).
- A write to TRIGGER_ADDR in the same cycle dma_done is high is accepted normally.
- A CPU read of TRIGGER_ADDR, or a write to any other address, has no effect.
- page=8'h00 is legal: the source is zero-page RAM.

Decomposition:
- Shared package nes_bus_pkg:
  - address constants ADDR_OAMDMA=16'h4014 and ADDR_OAMDATA=16'h2004, reused by top-level decode.
  - dma_state_t enum {IDLE,DUMMY,ALIGN,READ,WAIT,WRITE}.
- No sub-module is warranted: one FSM plus an idx counter and a wait counter.
- The top level replaces dma_addr_hi/lo regs with dma_addr and ORs dma_wr_en into the bus write path.

Test Plan:
- Trigger with page 8'h02, RAM preloaded with $0200+i = i^8'hA5, parity even: 256 writes to $2004 with data i^8'hA5 in order; dma_en high exactly 513 cycles; dma_done pulses once.
- Same trigger one cycle later (parity odd): dma_en high 514 cycles; first READ addresses $0200 two cycles after DUMMY.
- page=8'h07: last read is $07FF, then a write to $2004; no access to $0800.
- Reset asserted at byte 100's WRITE: dma_en=0 next cycle; no dma_done; later trigger with page 8'h03 runs a full 256 writes from $0300.
- CPU read at $4014 and write at $4015: no transfer. Trigger held during the transfer: ignored, count stays 256.
- READ_LATENCY=2 build: per-byte period 3 cycles; dma_en high 769/770 cycles; data correct.
